// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: op codes, amount-source selects, FSM states.
// Pure definitions, no logic; no latency or flow control of its own.
// Imported by shift_amt_sel and shift_seq_ctrl.
package shift_seq_pkg;

    typedef enum logic [2:0] {
        OP_SLL  = 3'b000,
        OP_SRL  = 3'b001,
        OP_SRA  = 3'b010,
        OP_SLLV = 3'b011,
        OP_SRLV = 3'b100,
        OP_SRAV = 3'b101,
        OP_LUI  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    localparam logic [1:0] NSEL_CONST = 2'b00;
    localparam logic [1:0] NSEL_SHAMT = 2'b10;
    localparam logic [1:0] NSEL_RS    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_amt_sel.sv
// Picks the shift amount N and its source select from the op code.
// Purely combinational, zero latency.
// No flow control; the caller samples the outputs only when it accepts a command.
module shift_amt_sel
    import shift_seq_pkg::*;
#(
    parameter int N_W   = 5,
    parameter int LUI_N = 16
) (
    input  logic [2:0]     op,
    input  logic [N_W-1:0] shamt,
    input  logic [N_W-1:0] rs_lo,
    output logic [N_W-1:0] n,
    output logic [1:0]     n_sel
);

    always_comb begin
        n     = '0;
        n_sel = NSEL_CONST;
        case (op_e'(op))
            OP_SLL, OP_SRL, OP_SRA: begin
                n     = shamt;
                n_sel = NSEL_SHAMT;
            end
            OP_SLLV, OP_SRLV, OP_SRAV: begin
                n     = rs_lo;
                n_sel = NSEL_RS;
            end
            OP_LUI: begin
                n     = N_W'(LUI_N);
                n_sel = NSEL_CONST;
            end
            // Reserved op: zero shift, passes rt_val straight through.
            default: begin
                n     = '0;
                n_sel = NSEL_CONST;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multicycle shift sequencer: one bit per cycle, or single-cycle barrel shift with SHIFT_SEQ_FAST_EN.
// Latency: accept at cycle 0 -> done in cycle N+1 (always cycle 1 with SHIFT_SEQ_FAST_EN).
// Backpressure: start is ignored while busy, including the DONE cycle; inputs sampled only on accept.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 5,
    parameter int LUI_N  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [N_W-1:0]    shamt,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic [1:0]        n_sel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [1:0]        n_sel_q, n_sel_d;
    logic [N_W-1:0]    sel_n;
    logic [1:0]        sel_nsel;
    logic              unused_rs_hi;

    // Only the low N_W bits of rs_val carry a shift amount.
    assign unused_rs_hi = ^rs_val[DATA_W-1:N_W];

    shift_amt_sel #(
        .N_W   (N_W),
        .LUI_N (LUI_N)
    ) u_amt_sel (
        .op    (op),
        .shamt (shamt),
        .rs_lo (rs_val[N_W-1:0]),
        .n     (sel_n),
        .n_sel (sel_nsel)
    );

`ifdef SHIFT_SEQ_FAST_EN
    function automatic logic [DATA_W-1:0] shift_n(input op_e o, input logic [DATA_W-1:0] d,
                                                  input logic [N_W-1:0] n);
        case (o)
            OP_SLL, OP_SLLV, OP_LUI: return d << n;
            OP_SRL, OP_SRLV:         return d >> n;
            OP_SRA, OP_SRAV:         return $unsigned($signed(d) >>> n);
            default:                 return d;
        endcase
    endfunction
`else
    logic [N_W-1:0] cnt_q, cnt_d;
    op_e            op_q, op_d;

    function automatic logic [DATA_W-1:0] shift_one(input op_e o, input logic [DATA_W-1:0] d);
        case (o)
            OP_SLL, OP_SLLV, OP_LUI: return {d[DATA_W-2:0], 1'b0};
            OP_SRL, OP_SRLV:         return {1'b0, d[DATA_W-1:1]};
            OP_SRA, OP_SRAV:         return {d[DATA_W-1], d[DATA_W-1:1]};
            default:                 return d;
        endcase
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        result_d = result_q;
        n_sel_d  = n_sel_q;
`ifndef SHIFT_SEQ_FAST_EN
        cnt_d    = cnt_q;
        op_d     = op_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_sel_d = sel_nsel;
`ifdef SHIFT_SEQ_FAST_EN
                    data_d  = shift_n(op_e'(op), rt_val, sel_n);
                    state_d = ST_DONE;
`else
                    op_d    = op_e'(op);
                    data_d  = rt_val;
                    cnt_d   = sel_n;
                    state_d = (sel_n == '0) ? ST_DONE : ST_SHIFT;
`endif
                end
            end
`ifndef SHIFT_SEQ_FAST_EN
            ST_SHIFT: begin
                data_d = shift_one(op_q, data_q);
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == N_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Load the result on entry to DONE so it is valid during the done pulse and held afterwards.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            result_d = data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            result_q <= '0;
            n_sel_q  <= NSEL_CONST;
`ifndef SHIFT_SEQ_FAST_EN
            cnt_q    <= '0;
            op_q     <= OP_SLL;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            result_q <= result_d;
            n_sel_q  <= n_sel_d;
`ifndef SHIFT_SEQ_FAST_EN
            cnt_q    <= cnt_d;
            op_q     <= op_d;
`endif
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign n_sel  = n_sel_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl; expected latencies follow SHIFT_SEQ_FAST_EN when defined.
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic [2:0]  op     = 3'b000;
    logic [4:0]  shamt  = 5'd0;
    logic [31:0] rs_val = 32'h0;
    logic [31:0] rt_val = 32'h0;
    logic [1:0]  n_sel;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.DATA_W(32), .N_W(5), .LUI_N(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .shamt  (shamt),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .n_sel  (n_sel),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat(input int n);
`ifdef SHIFT_SEQ_FAST_EN
        return 1 + 0 * n;
`else
        return n + 1;
`endif
    endfunction

    // Drives one accepted command at cycle 0, then scrambles the inputs while busy.
    task automatic issue(input logic [2:0] o, input logic [4:0] sa, input logic [31:0] rs,
                         input logic [31:0] rt);
        op = o; shamt = sa; rs_val = rs; rt_val = rt; start = 1'b1;
        step();
        start = 1'b0; op = 3'b001; shamt = 5'h1F; rs_val = 32'hFFFFFFFF; rt_val = 32'hDEADBEEF;
    endtask

    task automatic wait_done(output int cyc, output logic [31:0] res, output logic bok);
        cyc = -1; res = 32'hx; bok = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            bok = bok & busy;
            if (done === 1'b1) begin
                cyc = c; res = result;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
        n_cmp++; if (n_sel !== 2'b00) begin n_bad++; $display("FAIL reset_nsel: got %b want 00", n_sel); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_sra();
        int cyc; logic [31:0] res; logic bok;
        step();
        issue(OP_SRA, 5'd4, 32'h0, 32'h80000000);
        wait_done(cyc, res, bok);
        n_cmp++; if (cyc !== lat(4)) begin n_bad++; $display("FAIL sra_latency: got %0d want %0d", cyc, lat(4)); end
        n_cmp++; if (res !== 32'hF8000000) begin n_bad++; $display("FAIL sra_result: got %h want f8000000", res); end
        n_cmp++; if (n_sel !== 2'b10) begin n_bad++; $display("FAIL sra_nsel: got %b want 10", n_sel); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL sra_busy: got %b want 1", bok); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sra_idle: got busy %b want 0", busy); end
        n_cmp++; if (result !== 32'hF8000000) begin n_bad++; $display("FAIL sra_hold: got %h want f8000000", result); end
    endtask

    task automatic test_sllv();
        int cyc; logic [31:0] res; logic bok;
        step();
        issue(OP_SLLV, 5'd9, 32'h00000023, 32'h00000001);
        wait_done(cyc, res, bok);
        n_cmp++; if (cyc !== lat(3)) begin n_bad++; $display("FAIL sllv_latency: got %0d want %0d", cyc, lat(3)); end
        n_cmp++; if (res !== 32'h00000008) begin n_bad++; $display("FAIL sllv_result: got %h want 00000008", res); end
        n_cmp++; if (n_sel !== 2'b11) begin n_bad++; $display("FAIL sllv_nsel: got %b want 11", n_sel); end
        step();
    endtask

    task automatic test_lui();
        int cyc; logic [31:0] res; logic bok;
        step();
        issue(OP_LUI, 5'd3, 32'h00000005, 32'h0000ABCD);
        wait_done(cyc, res, bok);
        n_cmp++; if (cyc !== lat(16)) begin n_bad++; $display("FAIL lui_latency: got %0d want %0d", cyc, lat(16)); end
        n_cmp++; if (res !== 32'hABCD0000) begin n_bad++; $display("FAIL lui_result: got %h want abcd0000", res); end
        n_cmp++; if (n_sel !== 2'b00) begin n_bad++; $display("FAIL lui_nsel: got %b want 00", n_sel); end
        n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL lui_busy: got %b want 1", bok); end
        step();
    endtask

    task automatic test_zero_and_rsvd();
        int cyc; logic [31:0] res; logic bok;
        step();
        issue(OP_SLL, 5'd0, 32'h0000001F, 32'h12345678);
        wait_done(cyc, res, bok);
        n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL zero_latency: got %0d want 1", cyc); end
        n_cmp++; if (res !== 32'h12345678) begin n_bad++; $display("FAIL zero_result: got %h want 12345678", res); end
        step();
        issue(OP_RSVD, 5'd5, 32'h00000003, 32'h0BADF00D);
        wait_done(cyc, res, bok);
        n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL rsvd_latency: got %0d want 1", cyc); end
        n_cmp++; if (res !== 32'h0BADF00D) begin n_bad++; $display("FAIL rsvd_result: got %h want 0badf00d", res); end
        step();
    endtask

    task automatic test_busy_ignore();
        int cyc = -1;
        int inj;
        logic [31:0] res = 32'hx;
`ifdef SHIFT_SEQ_FAST_EN
        inj = 1;
`else
        inj = 3;
`endif
        step();
        issue(OP_SRL, 5'd8, 32'h0, 32'hFF000000);
        for (int c = 1; c <= 64; c++) begin
            if (c == inj) begin
                start = 1'b1; op = OP_SLL; shamt = 5'd1; rt_val = 32'h00000001;
            end
            if (c == inj + 1) start = 1'b0;
            if (done === 1'b1) begin
                cyc = c; res = result;
                break;
            end
            step();
        end
        n_cmp++; if (cyc !== lat(8)) begin n_bad++; $display("FAIL ignore_latency: got %0d want %0d", cyc, lat(8)); end
        n_cmp++; if (res !== 32'h00FF0000) begin n_bad++; $display("FAIL ignore_result: got %h want 00ff0000", res); end
        step();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_idle1: got busy %b want 0", busy); end
        step();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL ignore_idle2: got busy %b done %b want 0 0", busy, done);
        end
        n_cmp++; if (result !== 32'h00FF0000) begin n_bad++; $display("FAIL ignore_hold: got %h want 00ff0000", result); end
    endtask

    task automatic test_back_to_back();
        int l = lat(2);
        int c1 = -1;
        int c2 = -1;
        logic [31:0] r1 = 32'h0;
        logic [31:0] r2 = 32'h0;
        logic gap_idle = 1'b0;
        step();
        op = OP_SLL; shamt = 5'd2; rs_val = 32'h0; rt_val = 32'h00000001; start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 2) rt_val = 32'h00000003;
            if (c == l + 1) gap_idle = ~busy;
            if (done === 1'b1 && c1 < 0) begin
                c1 = c; r1 = result;
            end else if (done === 1'b1 && c2 < 0) begin
                c2 = c; r2 = result; start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        n_cmp++; if (c1 !== l) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want %0d", c1, l); end
        n_cmp++; if (r1 !== 32'h00000004) begin n_bad++; $display("FAIL b2b_first_result: got %h want 00000004", r1); end
        n_cmp++; if (gap_idle !== 1'b1) begin n_bad++; $display("FAIL b2b_gap: got idle %b want 1", gap_idle); end
        n_cmp++; if (c2 !== 2 * l + 1) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want %0d", c2, 2 * l + 1); end
        n_cmp++; if (r2 !== 32'h0000000C) begin n_bad++; $display("FAIL b2b_second_result: got %h want 0000000c", r2); end
        step();
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        int exp_done;
        int cyc; logic [31:0] res; logic bok;
`ifdef SHIFT_SEQ_FAST_EN
        exp_done = 1;
`else
        exp_done = 0;
`endif
        step();
        issue(OP_SRLV, 5'd1, 32'h00000014, 32'hF0000000);
        for (int c = 1; c < 7; c++) begin
            if (c == 6) reset = 1'b1;
            if (done === 1'b1) ndone++;
            step();
        end
        reset = 1'b0;
        n_cmp++; if (ndone !== exp_done) begin n_bad++; $display("FAIL abort_done_count: got %0d want %0d", ndone, exp_done); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL abort_state: got busy %b done %b want 0 0", busy, done);
        end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL abort_result: got %h want 0", result); end
        n_cmp++; if (n_sel !== 2'b00) begin n_bad++; $display("FAIL abort_nsel: got %b want 00", n_sel); end
        step();
        issue(OP_SRLV, 5'd1, 32'h00000014, 32'hF0000000);
        wait_done(cyc, res, bok);
        n_cmp++; if (cyc !== lat(20)) begin n_bad++; $display("FAIL abort_restart_latency: got %0d want %0d", cyc, lat(20)); end
        n_cmp++; if (res !== 32'h00000F00) begin n_bad++; $display("FAIL abort_restart_result: got %h want 00000f00", res); end
        n_cmp++; if (n_sel !== 2'b11) begin n_bad++; $display("FAIL abort_restart_nsel: got %b want 11", n_sel); end
        step();
    endtask

    initial begin
        test_reset();
        test_sra();
        test_sllv();
        test_lui();
        test_zero_and_rsvd();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multicycle shift sequencer for the processor datapath.
- Accepts a shift command from the main control unit and selects the shift amount N from one of three sources: instruction shamt field, rs register low 5 bits, or the constant 16 used by LUI.
- Performs the shift one bit per cycle on an internal data register, then returns the result with a one-cycle done pulse.
- Sits between the control FSM and the ALU-out/register-file write path.

Parameters:
- DATA_W, 32, width of the shifted operand.
- N_W, 5, shift-amount width; N ranges 0..2^N_W-1.
- LUI_N, 16, constant shift amount for LUI.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; accepted only when busy=0.
- op  input  3  000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRLV, 101 SRAV, 110 LUI, 111 reserved.
- shamt  input  N_W  instruction bits [10:6].
- rs_val  input  DATA_W  variable-shift source; only rs_val[N_W-1:0] is used.
- rt_val  input  DATA_W  operand to shift.
- n_sel  output  2  amount-source select: 2'b10 shamt, 2'b11 rs, 2'b00 constant LUI_N.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  DATA_W  shifted value; held until the next accepted start.

Behaviour:
- Reset (synchronous, active-high) values: state=IDLE, result=0, busy=0, done=0, n_sel=2'b00, counter=0.
- Reset asserted mid-operation aborts the operation. No done is produced. State returns to IDLE next edge with the reset values above.
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, capture rt_val into the data register (LUI also uses rt_val) and latch op.
  - Set n_sel: SLL/SRL/SRA -> 10, SLLV/SRLV/SRAV -> 11, LUI -> 00.
  - Load counter with the selected N.
  - Next state is SHIFT if N!=0, else DONE.
- SHIFT:
  - Each cycle, shift the data register one bit and decrement the counter.
  - SLL/SLLV/LUI shift left, zero-filling. SRL/SRLV shift right, zero-filling. SRA/SRAV shift right, replicating the MSB.
  - When counter==1, perform the final shift and go to DONE.
- DONE: done=1, result=data register, next state IDLE.
- Latency: an accepted start at cycle 0 gives done in cycle N+1.
  - N=0 gives done in cycle 1 with result = rt_val.
  - Maximum is cycle 32 (N=31).
- start while busy=1 is ignored and no state changes. start in the DONE cycle is also ignored; the earliest new accept is the cycle after DONE.
- Reserved op 111: treated as N=0, go directly to DONE, result = rt_val.
- n_sel holds its value from accept until the next accept.
- Counter arithmetic is unsigned N_W bits and never wraps; SHIFT exits at counter==1.
- Inputs other than start are sampled only in the accept cycle. Changes while busy have no effect.

Optional Feature:
- Macro: SHIFT_SEQ_FAST_EN.
- Defined: the block uses a single-cycle barrel shift. IDLE goes straight to DONE for every op, so done is always in cycle 1 and the SHIFT state is not synthesized. n_sel behaves the same.
- Undefined: iterative one-bit-per-cycle behaviour as above.
- Result values are identical in both builds.

Decomposition:
- Shared package shift_seq_pkg holds:
  - op codes (OP_SLL .. OP_LUI, OP_RSVD);
  - n_sel constants (NSEL_CONST=2'b00, NSEL_SHAMT=2'b10, NSEL_RS=2'b11);
  - state encoding (ST_IDLE, ST_SHIFT, ST_DONE).
- One sub-module is natural: shift_amt_sel. It is combinational: maps op, shamt and rs_val[N_W-1:0] to N and n_sel.
- The FSM, counter and data register stay in shift_seq_ctrl.

Test Plan:
- SRA, rt_val=0x80000000, shamt=4, start at cycle 0 -> n_sel=10, busy cycles 1–5, done in cycle 5, result=0xF8000000.
- SLLV, rs_val=0x00000023 (N=3), rt_val=0x00000001 -> n_sel=11, done in cycle 4, result=0x00000008.
- LUI, rt_val=0x0000ABCD -> n_sel=00, done in cycle 17, result=0xABCD0000. With SHIFT_SEQ_FAST_EN defined, done in cycle 1 with the same result.
- SLL, shamt=0, rt_val=0x12345678 -> done in cycle 1, result=0x12345678. Same response for op=111.
- SRL with N=8 on 0xFF000000, second start pulsed at cycle 3 -> second start ignored, done in cycle 9, result=0x00FF0000, then IDLE.
- SRLV with N=20, reset asserted at cycle 6 -> no done pulse; from cycle 7 result=0, busy=0, state IDLE; a new start at cycle 8 is accepted normally.
